// File: rtl/rf_wb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
package rf_wb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;

    // Register 0 is hard-wired; writes to it are swallowed.
    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LNG  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO buffering long-latency write-back results.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges ALU and long-latency results onto the single RF write port and
// tracks pending long-latency destinations in a busy scoreboard.
module rf_write_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDR_W-1:0]           alu_addr,
    input  logic [DATA_W-1:0]           alu_data,
    input  logic                        lng_valid,
    output logic                        lng_ready,
    input  logic [ADDR_W-1:0]           lng_addr,
    input  logic [DATA_W-1:0]           lng_data,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [ADDR_W-1:0]           issue_addr,
    input  logic [ADDR_W-1:0]           rs_addr,
    input  logic [ADDR_W-1:0]           rt_addr,
    output logic                        rs_busy,
    output logic                        rt_busy,
    output logic                        RegWrite,
    output logic [ADDR_W-1:0]           Rd_Addr,
    output logic [DATA_W-1:0]           Rd_Data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

    entry_t              alu_entry;
    entry_t              lng_entry;
    entry_t              head;
    entry_t              sel_entry;
    wb_src_e             sel_src;
    wb_src_e             src_p1;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                sel_write;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    assign alu_entry   = '{addr: alu_addr, data: alu_data};
    assign lng_entry   = '{addr: lng_addr, data: lng_data};

    // Ready signals depend only on state, never on the matching valid.
    assign alu_ready   = !fifo_full;
    assign lng_ready   = !fifo_full;
    assign issue_ready = !busy[issue_addr];
    assign rs_busy     = busy[rs_addr];
    assign rt_busy     = busy[rt_addr];

    assign fifo_push   = lng_valid && lng_ready;
    assign fifo_pop    = (sel_src == SRC_LNG);

    rf_wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (lng_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Write-source priority: a full FIFO drains first so ALU traffic cannot starve it.
    always_comb begin
        sel_src   = SRC_NONE;
        sel_entry = head;
        if (fifo_full) begin
            sel_src = SRC_LNG;
        end else if (alu_valid) begin
            sel_src   = SRC_ALU;
            sel_entry = alu_entry;
        end else if (!fifo_empty) begin
            sel_src = SRC_LNG;
        end
    end

    // Register 0 writes are consumed but never reach the RF.
    assign sel_write = (sel_src != SRC_NONE) && (sel_entry.addr != ADDR_ZERO);

    // RF write port register; address/data hold when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            Rd_Addr  <= '0;
            Rd_Data  <= '0;
            src_p1   <= SRC_NONE;
        end else begin
            RegWrite <= sel_write;
            src_p1   <= sel_write ? sel_src : SRC_NONE;
            if (sel_write) begin
                Rd_Addr <= sel_entry.addr;
                Rd_Data <= sel_entry.data;
            end
        end
    end

    // Scoreboard update: clear on the edge the RF captures a long-latency write, set on issue.
    always_comb begin
        busy_nxt = busy;
        if (RegWrite && (src_p1 == SRC_LNG)) begin
            busy_nxt[Rd_Addr] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_addr != ADDR_ZERO)) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    // Busy vector state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter with a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              lng_valid;
    logic              lng_ready;
    logic [ADDR_W-1:0] lng_addr;
    logic [DATA_W-1:0] lng_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_busy;
    logic              rt_busy;
    logic              RegWrite;
    logic [ADDR_W-1:0] Rd_Addr;
    logic [DATA_W-1:0] Rd_Data;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    wr_t       mq[$];      // buffered long-latency results, oldest first
    wr_t       exp_q[$];   // RF writes expected at the next edge
    bit [31:0] mbusy;
    bit        pend_clr_v;
    int        pend_clr_a;

    rf_write_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .NUM_REGS   (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .lng_valid   (lng_valid),
        .lng_ready   (lng_ready),
        .lng_addr    (lng_addr),
        .lng_data    (lng_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_addr  (issue_addr),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .RegWrite    (RegWrite),
        .Rd_Addr     (Rd_Addr),
        .Rd_Data     (Rd_Data),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus: drive at the falling edge, check combinational
    // outputs against the model, then advance the model past the next rising edge.
    task automatic cycle(input bit av, input int aa, input logic [DATA_W-1:0] ad,
                         input bit lv, input int la, input logic [DATA_W-1:0] ld,
                         input bit iv, input int ia, input int ra, input int ta);
        bit  full;
        bit  iss_ok;
        bit  wr_v;
        bit  from_fifo;
        wr_t w;
        @(negedge clk);
        alu_valid   = av;
        alu_addr    = ADDR_W'(aa);
        alu_data    = ad;
        lng_valid   = lv;
        lng_addr    = ADDR_W'(la);
        lng_data    = ld;
        issue_valid = iv;
        issue_addr  = ADDR_W'(ia);
        rs_addr     = ADDR_W'(ra);
        rt_addr     = ADDR_W'(ta);
        #1;
        full   = (mq.size() == DEPTH);
        iss_ok = !mbusy[ia];
        check("alu_ready",   alu_ready,   !full);
        check("lng_ready",   lng_ready,   !full);
        check("issue_ready", issue_ready, iss_ok);
        check("rs_busy",     rs_busy,     mbusy[ra]);
        check("rt_busy",     rt_busy,     mbusy[ta]);
        check("fifo_count",  fifo_count,  mq.size());

        wr_v      = 1'b0;
        from_fifo = 1'b0;
        w         = '0;
        if (full) begin
            w = mq.pop_front();
            wr_v = 1'b1;
            from_fifo = 1'b1;
        end else if (av) begin
            w = '{addr: ADDR_W'(aa), data: ad};
            wr_v = 1'b1;
        end else if (mq.size() > 0) begin
            w = mq.pop_front();
            wr_v = 1'b1;
            from_fifo = 1'b1;
        end
        if (lv && !full) mq.push_back('{addr: ADDR_W'(la), data: ld});
        if (wr_v && w.addr != 0) exp_q.push_back(w);

        if (pend_clr_v) mbusy[pend_clr_a] = 1'b0;
        if (iv && iss_ok && ia != 0) mbusy[ia] = 1'b1;
        pend_clr_v = wr_v && from_fifo && (w.addr != 0);
        pend_clr_a = int'(w.addr);
    endtask

    task automatic idle(input int n, input int ra);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, '0, 0, 0, ra, ra);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        mbusy      = '0;
        pend_clr_v = 1'b0;
        pend_clr_a = 0;
    endtask

    // Monitor: every RF write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (RegWrite) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {RegWrite, Rd_Addr}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("Rd_Addr", Rd_Addr, e.addr);
                    check("Rd_Data", Rd_Data, e.data);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("missed_write", RegWrite, 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        alu_valid   = 1'b0;
        alu_addr    = '0;
        alu_data    = '0;
        lng_valid   = 1'b0;
        lng_addr    = '0;
        lng_data    = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        rs_addr     = '0;
        rt_addr     = '0;
        model_reset();
        #1;
        check("rst_RegWrite",   RegWrite,   0);
        check("rst_Rd_Addr",    Rd_Addr,    0);
        check("rst_Rd_Data",    Rd_Data,    0);
        check("rst_fifo_count", fifo_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ALU write to r3 appears one cycle later
        cycle(1, 3, 32'h11, 0, 0, '0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("t1_RegWrite", RegWrite, 1);
        check("t1_Rd_Addr",  Rd_Addr,  3);
        check("t1_Rd_Data",  Rd_Data,  32'h11);

        // issue r5, then its long-latency result; busy until the RF captures it
        cycle(0, 0, '0, 0, 0, '0, 1, 5, 5, 5);
        cycle(0, 0, '0, 1, 5, 32'hAB, 0, 0, 5, 5);
        check("t2_rs_busy_pending", rs_busy, 1);
        idle(4, 5);
        check("t2_rs_busy_cleared", rs_busy, 0);

        // fill FIFO while ALU hogs the port, then observe the anti-starvation cycle
        for (int i = 0; i < 4; i++) cycle(1, 20 + i, 32'h100 + i, 1, 10 + i, 32'h200 + i, 0, 0, 0, 0);
        cycle(1, 24, 32'h104, 1, 14, 32'h204, 0, 0, 0, 0);
        check("t3_alu_ready_full", alu_ready, 0);
        check("t3_lng_ready_full", lng_ready, 0);
        idle(6, 0);

        // double issue to r7, and issue to r0
        cycle(0, 0, '0, 0, 0, '0, 1, 7, 7, 0);
        cycle(0, 0, '0, 0, 0, '0, 1, 7, 7, 0);
        check("t4_second_issue_ready", issue_ready, 0);
        cycle(0, 0, '0, 0, 0, '0, 1, 0, 0, 7);
        check("t4_issue_r0_ready", issue_ready, 1);
        idle(1, 0);
        check("t4_r0_not_busy", rs_busy, 0);

        // ALU write to r0 never drives RegWrite
        cycle(1, 0, 32'hFF, 0, 0, '0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("t5_r0_RegWrite", RegWrite, 0);

        // reset with buffered results and a busy register
        cycle(0, 0, '0, 0, 0, '0, 1, 9, 9, 9);
        for (int i = 0; i < 3; i++) cycle(1, 1 + i, 32'h300 + i, 1, 9, 32'h400 + i, 0, 0, 9, 9);
        @(negedge clk);
        alu_valid   = 1'b0;
        lng_valid   = 1'b0;
        issue_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("t6_RegWrite",   RegWrite,   0);
        check("t6_fifo_count", fifo_count, 0);
        check("t6_rs_busy9",   rs_busy,    0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 99) < 50, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 99) < 40, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 99) < 30, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
        end
        idle(8, 0);
        @(posedge clk);
        #2;
        check("final_exp_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
